// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - FSM state encodings for the receiver
//   - parity type selectors
//   - parity_bit(): the parity bit value for a data word
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_START  = 3'd1;
  localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] S_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] S_STOP   = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE   = 3'd5;
  localparam logic [STATE_W-1:0] S_BREAK  = 3'd6;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Unused upper bits must be zero; they do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned             parity_type);
    logic p;
    p = ^data;
    return (parity_type == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and parallel word/status outputs of the receiver.
//   master : the receiver (drives word, status and busy; reads the line)
//   slave  : the line driver / word consumer
interface uart_rx_if #(
  parameter int unsigned P_DATA_BITS = 8
);
  logic                   i_serial_rx;
  logic [P_DATA_BITS-1:0] o_rx_data;
  logic                   o_rx_data_valid;
  logic                   o_parity_err;
  logic                   o_frame_err;
  logic                   o_rx_busy;

  modport master (
    input  i_serial_rx,
    output o_rx_data, o_rx_data_valid, o_parity_err, o_frame_err, o_rx_busy
  );

  modport slave (
    output i_serial_rx,
    input  o_rx_data, o_rx_data_valid, o_parity_err, o_frame_err, o_rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an idle-high asynchronous line.
//   i_clk, i_rst (async, active high) ; i_async raw line ; o_sync synced line
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, LSB-first, start=0, stop=1, mid-bit sampling.
//   i_clk, i_rst (async, active high)
//   bus.i_serial_rx      raw serial line, idle high
//   bus.o_rx_data        last received word (held between frames)
//   bus.o_rx_data_valid  one-cycle pulse per received frame
//   bus.o_parity_err     parity mismatch of the presented word
//   bus.o_frame_err      a sampled stop bit was 0
//   bus.o_rx_busy        FSM not idle
// Build option UART_RX_MAJORITY_VOTE_EN: each sample is the 2-of-3 majority
// around the strobe, decided one cycle after the strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_DATA_BITS    = 8,
  parameter int unsigned P_PARITY_TYPE  = 0,
  parameter int unsigned P_STOP_BITS    = 1,
  parameter int unsigned P_CLKS_PER_BIT = 16
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(P_CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(P_DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(P_CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(P_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_STOP_BITS - 1);

  logic                   rx_sync;
  logic                   strobe;
  logic                   sample_en;
  logic                   sample_bit;

  logic [STATE_W-1:0]     state_q,      state_d;
  logic [CNT_W-1:0]       cnt_q,        cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [P_DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                   par_flag_q,   par_flag_d;
  logic                   frame_flag_q, frame_flag_d;
  logic [P_DATA_BITS-1:0] rx_data_q,    rx_data_d;
  logic                   valid_q,      valid_d;
  logic                   perr_q,       perr_d;
  logic                   ferr_q,       ferr_d;
  logic                   busy_q,       busy_d;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (bus.i_serial_rx),
    .o_sync  (rx_sync)
  );

  // Counter is held at 0 outside the bit-timing states, so no stray strobe.
  assign strobe = (cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] = line one cycle ago, hist_q[1] = two cycles ago.
  logic [1:0] hist_q, hist_d;
  logic       strobe_q, strobe_d;

  always_comb begin
    hist_d   = {hist_q[0], rx_sync};
    strobe_d = strobe;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist_q   <= 2'b11;
      strobe_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      strobe_q <= strobe_d;
    end
  end

  assign sample_en  = strobe_q;
  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) | (hist_q[0] & rx_sync);
`else
  assign sample_en  = strobe;
  assign sample_bit = rx_sync;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_flag_d   = par_flag_q;
    frame_flag_d = frame_flag_q;
    rx_data_d    = rx_data_q;
    valid_d      = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    busy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_sync) state_d = S_START;
      end
      S_START: begin
        if (sample_en) begin
          if (sample_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_DATA;
            bit_cnt_d    = '0;
            par_flag_d   = 1'b0;
            frame_flag_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample_en) begin
          shreg_d   = {sample_bit, shreg_q[P_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (P_PARITY_TYPE != PARITY_NONE) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample_en) begin
          par_flag_d = (sample_bit != parity_bit(MAX_DATA_BITS'(shreg_q), P_PARITY_TYPE));
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_en) begin
          frame_flag_d = frame_flag_q | ~sample_bit;
          bit_cnt_d    = bit_cnt_q + 1'b1;
          // Word and status are registered as DONE is entered, so they are
          // presented during the single DONE cycle.
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = S_DONE;
            rx_data_d = shreg_q;
            perr_d    = par_flag_q;
            ferr_d    = frame_flag_d;
            valid_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // A line still low after a bad stop bit is a break, not a new start.
        state_d = (frame_flag_q && !rx_sync) ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (rx_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Baud counter: loaded half a bit on start detect, free-running while framing.
    if (state_d == S_START || state_d == S_DATA || state_d == S_PARITY || state_d == S_STOP) begin
      if (state_q == S_IDLE)      cnt_d = CNT_START;
      else if (cnt_q == CNT_LAST) cnt_d = '0;
      else                        cnt_d = cnt_q + 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_flag_q   <= 1'b0;
      frame_flag_q <= 1'b0;
      rx_data_q    <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_flag_q   <= par_flag_d;
      frame_flag_q <= frame_flag_d;
      rx_data_q    <= rx_data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_rx_data       = rx_data_q;
  assign bus.o_rx_data_valid = valid_q;
  assign bus.o_parity_err    = perr_q;
  assign bus.o_frame_err     = ferr_q;
  assign bus.o_rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Instance A is 8N1, instance B is
// 8E1, both 16 clocks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB   = 16;
  localparam int          CLK_P = 10;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MV = 1;
`else
  localparam int MV = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ln_a = 1'b1;
  logic ln_b = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if #(.P_DATA_BITS(8)) bus_a ();
  uart_rx_if #(.P_DATA_BITS(8)) bus_b ();

  assign bus_a.i_serial_rx = ln_a;
  assign bus_b.i_serial_rx = ln_b;

  uart_rx #(.P_DATA_BITS(8), .P_PARITY_TYPE(PARITY_NONE), .P_STOP_BITS(1),
            .P_CLKS_PER_BIT(CPB)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.master));
  uart_rx #(.P_DATA_BITS(8), .P_PARITY_TYPE(PARITY_EVEN), .P_STOP_BITS(1),
            .P_CLKS_PER_BIT(CPB)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.master));

  typedef struct {
    longint     t;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } pulse_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par_en;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  pulse_t qa[$];
  pulse_t qb[$];
  logic   prev_va = 1'b0, prev_vb = 1'b0;
  logic   dbl_a = 1'b0, dbl_b = 1'b0;
  int     checks = 0;
  int     errors = 0;

  // Record every valid pulse with the posedge time at which it rose.
  always @(negedge clk) begin
    pulse_t p;
    if (bus_a.o_rx_data_valid) begin
      if (prev_va) dbl_a = 1'b1;
      p.t = longint'($time) - 5; p.data = bus_a.o_rx_data;
      p.perr = bus_a.o_parity_err; p.ferr = bus_a.o_frame_err;
      qa.push_back(p);
    end
    if (bus_b.o_rx_data_valid) begin
      if (prev_vb) dbl_b = 1'b1;
      p.t = longint'($time) - 5; p.data = bus_b.o_rx_data;
      p.perr = bus_b.o_parity_err; p.ferr = bus_b.o_frame_err;
      qb.push_back(p);
    end
    prev_va = bus_a.o_rx_data_valid;
    prev_vb = bus_b.o_rx_data_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) ln_a = v;
    else           ln_b = v;
  endtask

  // Called and returns 1 time unit after a posedge.
  task automatic hold_bit(input int inst, input logic v);
    set_line(inst, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Bit with a one-cycle inverted pulse at the mid-bit sample point.
  task automatic glitch_bit(input int inst, input logic v);
    set_line(inst, v);
    repeat (CPB / 2) @(posedge clk);
    #1 set_line(inst, ~v);
    @(posedge clk);
    #1 set_line(inst, v);
    repeat (CPB / 2 - 1) @(posedge clk);
    #1;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // t0 = time of the posedge just before the raw falling edge.
  task automatic send_frame(input int inst, input logic [7:0] d, input logic par_en,
                            input logic par, input logic stop, output longint t0);
    t0 = longint'($time) - 1;
    hold_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(inst, d[i]);
    if (par_en) hold_bit(inst, par);
    hold_bit(inst, stop);
  endtask

  vec_t   vecs[10];
  pulse_t p;
  longint t0, tx;
  int     nb, na, lat;
  logic [7:0] d5a;

  initial begin
    vecs[0] = '{0, 8'hA5, 0, 0, 1, 8'hA5, 0, 0};
    vecs[1] = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
    vecs[2] = '{0, 8'hFF, 0, 0, 1, 8'hFF, 0, 0};
    vecs[3] = '{0, 8'h55, 0, 0, 0, 8'h55, 0, 1};
    vecs[4] = '{0, 8'h11, 0, 0, 1, 8'h11, 0, 0};
    vecs[5] = '{1, 8'h07, 1, 0, 1, 8'h07, 1, 0};
    vecs[6] = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0};
    vecs[7] = '{1, 8'h96, 1, 0, 1, 8'h96, 0, 0};
    vecs[8] = '{1, 8'h80, 1, 1, 0, 8'h80, 0, 1};
    vecs[9] = '{1, 8'h3F, 1, 1, 1, 8'h3F, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_data",  64'(bus_a.o_rx_data), 64'h0);
    chk("rst_a_valid", 64'(bus_a.o_rx_data_valid), 64'h0);
    chk("rst_a_perr",  64'(bus_a.o_parity_err), 64'h0);
    chk("rst_a_ferr",  64'(bus_a.o_frame_err), 64'h0);
    chk("rst_a_busy",  64'(bus_a.o_rx_busy), 64'h0);
    chk("rst_b_data",  64'(bus_b.o_rx_data), 64'h0);
    chk("rst_b_busy",  64'(bus_b.o_rx_busy), 64'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Table of single frames
    for (int v = 0; v < 10; v++) begin
      nb = (vecs[v].inst == 0) ? qa.size() : qb.size();
      send_frame(vecs[v].inst, vecs[v].data, vecs[v].par_en, vecs[v].par, vecs[v].stop, t0);
      set_line(vecs[v].inst, 1'b1);
      repeat (2 * CPB) @(posedge clk);
      #1;
      na = (vecs[v].inst == 0) ? qa.size() : qb.size();
      chk($sformatf("v%0d_count", v), 64'(na), 64'(nb + 1));
      if (na == nb + 1) begin
        p   = (vecs[v].inst == 0) ? qa[na-1] : qb[na-1];
        lat = 2 + CPB / 2 + (8 + int'(vecs[v].par_en) + 1) * CPB + 1 + MV;
        chk($sformatf("v%0d_data", v), 64'(p.data), 64'(vecs[v].exp_data));
        chk($sformatf("v%0d_perr", v), 64'(p.perr), 64'(vecs[v].exp_perr));
        chk($sformatf("v%0d_ferr", v), 64'(p.ferr), 64'(vecs[v].exp_ferr));
        chk($sformatf("v%0d_latency", v), 64'(p.t - t0), 64'(lat * CLK_P));
      end
      chk($sformatf("v%0d_hold_data", v),
          64'((vecs[v].inst == 0) ? bus_a.o_rx_data : bus_b.o_rx_data), 64'(vecs[v].exp_data));
      chk($sformatf("v%0d_hold_ferr", v),
          64'((vecs[v].inst == 0) ? bus_a.o_frame_err : bus_b.o_frame_err), 64'(vecs[v].exp_ferr));
    end

    // False start: 4 low cycles, busy drops right after the start mid-sample
    nb = qa.size();
    set_line(0, 1'b0);
    repeat (4) @(posedge clk);
    #1 set_line(0, 1'b1);
    repeat (6 + MV) @(posedge clk);
    @(negedge clk);
    chk("false_busy_hi", 64'(bus_a.o_rx_busy), 64'h1);
    @(negedge clk);
    chk("false_busy_lo", 64'(bus_a.o_rx_busy), 64'h0);
    repeat (100) @(posedge clk);
    chk("false_no_valid", 64'(qa.size()), 64'(nb));

    // Break: bad stop bit then line held low
    align();
    nb = qa.size();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, t0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("brk_count", 64'(qa.size()), 64'(nb + 1));
    chk("brk_data",  64'(bus_a.o_rx_data), 64'h3C);
    chk("brk_ferr",  64'(bus_a.o_frame_err), 64'h1);
    chk("brk_busy",  64'(bus_a.o_rx_busy), 64'h1);
    align();
    set_line(0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("brk_idle", 64'(bus_a.o_rx_busy), 64'h0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, t0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("brk_rec_count", 64'(qa.size()), 64'(nb + 2));
    chk("brk_rec_data",  64'(bus_a.o_rx_data), 64'h11);
    chk("brk_rec_ferr",  64'(bus_a.o_frame_err), 64'h0);

    // Back-to-back frames with no idle gap
    nb = qa.size();
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, t0);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, tx);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, tx);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("b2b_count", 64'(qa.size()), 64'(nb + 3));
    if (qa.size() == nb + 3) begin
      chk("b2b_d0", 64'(qa[nb].data),   64'h00);
      chk("b2b_d1", 64'(qa[nb+1].data), 64'hFF);
      chk("b2b_d2", 64'(qa[nb+2].data), 64'h81);
      chk("b2b_lat0", 64'(qa[nb].t - t0), 64'((155 + MV) * CLK_P));
      chk("b2b_gap1", 64'(qa[nb+1].t - qa[nb].t), 64'(160 * CLK_P));
      chk("b2b_gap2", 64'(qa[nb+2].t - qa[nb+1].t), 64'(160 * CLK_P));
    end

    // Reset during data bit 4
    nb  = qa.size();
    d5a = 8'h5A;
    hold_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, d5a[i]);
    set_line(0, d5a[4]);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data",  64'(bus_a.o_rx_data), 64'h0);
    chk("mid_rst_valid", 64'(bus_a.o_rx_data_valid), 64'h0);
    chk("mid_rst_perr",  64'(bus_a.o_parity_err), 64'h0);
    chk("mid_rst_ferr",  64'(bus_a.o_frame_err), 64'h0);
    chk("mid_rst_busy",  64'(bus_a.o_rx_busy), 64'h0);
    align();
    set_line(0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", 64'(qa.size()), 64'(nb));
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("post_rst_count", 64'(qa.size()), 64'(nb + 1));
    chk("post_rst_data",  64'(bus_a.o_rx_data), 64'h5A);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Single-cycle glitches at the sample points of bits 2 and 3
    nb = qa.size();
    hold_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 3) glitch_bit(0, d5a[i]);
      else                  hold_bit(0, d5a[i]);
    end
    hold_bit(0, 1'b1);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("glitch_count", 64'(qa.size()), 64'(nb + 1));
    chk("glitch_data",  64'(bus_a.o_rx_data), 64'h5A);
`endif

    chk("valid_width_a", 64'(dbl_a), 64'h0);
    chk("valid_width_b", 64'(dbl_b), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
